// File: rtl/mult_pkg.sv
// Shared types and sizing for the iterative HI/LO multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

    localparam int MULT_WIDTH = 32;
    localparam int CNT_W      = $clog2(MULT_WIDTH);

endpackage

// File: rtl/mult_controller_if.sv
// Execute/Decode-side handshake and HI/LO result bundle of the multiplier.
interface mult_controller_if #(
    parameter int width = 32
);
    logic             start_E;
    logic             multSign_E;
    logic             flush_E;
    logic [width-1:0] srcA_E;
    logic [width-1:0] srcB_E;
    logic             hiLoRead_D;
    logic             mult_D;
    logic             busy;
    logic             stallMult;
    logic             done;
    logic [width-1:0] hi;
    logic [width-1:0] lo;

    modport master (
        output start_E, multSign_E, flush_E, srcA_E, srcB_E, hiLoRead_D, mult_D,
        input  busy, stallMult, done, hi, lo
    );

    modport slave (
        input  start_E, multSign_E, flush_E, srcA_E, srcB_E, hiLoRead_D, mult_D,
        output busy, stallMult, done, hi, lo
    );
endinterface

// File: rtl/mult_datapath.sv
// Radix-2 shift-add datapath: operand magnitudes, accumulator and final sign fix.
module mult_datapath #(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               sign,
    input  logic [width-1:0]   src_a,
    input  logic [width-1:0]   src_b,
    output logic [2*width-1:0] result
);

    logic [2*width-1:0] mcand;
    logic [2*width-1:0] acc;
    logic [2*width-1:0] acc_sum;
    logic [width-1:0]   mplier;
    logic [width-1:0]   mag_a;
    logic [width-1:0]   mag_b;
    logic               neg;

    // Two's-complement negate of the most negative value yields 2^(width-1) unsigned.
    assign mag_a = (sign & src_a[width-1]) ? (~src_a + width'(1)) : src_a;
    assign mag_b = (sign & src_b[width-1]) ? (~src_b + width'(1)) : src_b;

    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign result  = neg ? (~acc_sum + (2*width)'(1)) : acc_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            mcand  <= {{width{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            neg    <= sign & (src_a[width-1] ^ src_b[width-1]);
        end else if (step) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mult_controller.sv
// Sequencer for the iterative multiplier: FSM, iteration counter, stall request, HI/LO.
module mult_controller
    import mult_pkg::*;
#(
    parameter int width = MULT_WIDTH
) (
    input logic              clk,
    input logic              reset,
    mult_controller_if.slave bus
);

    localparam int cnt_w = (width > 1) ? $clog2(width) : 1;

    mult_state_t        state;
    mult_state_t        state_next;
    logic [cnt_w-1:0]   count;
    logic               accept;
    logic               last;
    logic [2*width-1:0] result;
    logic [width-1:0]   hi_q;
    logic [width-1:0]   lo_q;

    // Reset gating keeps busy/stall low while reset is held, even with start_E high.
    assign accept = bus.start_E & ~bus.flush_E & (state != CALC) & reset;
    assign last   = (state == CALC) && (count == cnt_w'(width - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? CALC : IDLE;
            CALC:       state_next = last ? DONE : CALC;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (state == CALC) begin
            count <= count + cnt_w'(1);
        end
    end

    // HI/LO only move on the final iteration edge, so old values stay readable during CALC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (last) begin
            {hi_q, lo_q} <= result;
        end
    end

    mult_datapath #(.width(width)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (state == CALC),
        .sign   (bus.multSign_E),
        .src_a  (bus.srcA_E),
        .src_b  (bus.srcB_E),
        .result (result)
    );

    assign bus.busy      = (state == CALC) | accept;
    assign bus.stallMult = bus.busy & (bus.hiLoRead_D | bus.mult_D);
    assign bus.done      = (state == DONE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule
